// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG external-memory bus sequencer.
package subneg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    HOLD   = 3'd2,
    RD     = 3'd3,
    SAMPLE = 3'd4,
    WDATA  = 3'd5,
    WSTB   = 3'd6,
    DONE   = 3'd7
  } state_e;

  localparam logic [7:0] DISP_ADDR_DEFAULT = 8'd21;
  localparam logic [7:0] BUS_DRIVE         = 8'hFF;
  localparam logic [7:0] BUS_RELEASE       = 8'h00;

  // Phase counters count down to zero, so a phase of n cycles loads n-1.
  function automatic logic [3:0] phase_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/subneg_mem_seq_if.sv
// Core request/response and pad-bus signals of the SUBNEG memory sequencer.
// Handshake: the core raises req with we/addr/wdata and holds req until it sees the one-cycle ack pulse.
interface subneg_mem_seq_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic [7:0] bus_in;
  logic       le;
  logic       moe;
  logic       mwe;
  logic [7:0] disp;

  modport master (
    output req, we, addr, wdata, bus_in,
    input  rdata, ack, bus_out, bus_oe, le, moe, mwe, disp
  );

  modport slave (
    input  req, we, addr, wdata, bus_in,
    output rdata, ack, bus_out, bus_oe, le, moe, mwe, disp
  );
endinterface

// File: rtl/subneg_phase_timer.sv
// 4-bit loadable down-counter with zero flag; times the ADDR, RD and WSTB phases.
module subneg_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/subneg_mem_seq.sv
// SUBNEG external-memory bus sequencer: core word requests -> LE/MOE/MWE cycles on the muxed pad bus.
// Optional memory-mapped display register enabled by defining SUBNEG_DISPLAY_EN.
module subneg_mem_seq
  import subneg_pkg::*;
#(
  parameter int unsigned LE_CYCLES = 1,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_CYCLES = 1,
  parameter logic [7:0]  DISP_ADDR = DISP_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  subneg_mem_seq_if.slave  io,
  output state_e           state_dbg
);

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       disp_hit_q, disp_hit_d;

  logic       le_q, le_d;
  logic       moe_q, moe_d;
  logic       mwe_q, mwe_d;
  logic       ack_q, ack_d;
  logic [7:0] bus_oe_q, bus_oe_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic [7:0] rdata_q, rdata_d;

  logic       tmr_load;
  logic [3:0] tmr_load_val;
  logic       tmr_dec;
  logic       tmr_zero;
  logic       disp_hit_now;

`ifdef SUBNEG_DISPLAY_EN
  assign disp_hit_now = io.we && (io.addr == DISP_ADDR);
`else
  assign disp_hit_now = io.we && (io.addr == DISP_ADDR) && 1'b0;
`endif

  subneg_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    disp_hit_d   = disp_hit_q;
    tmr_load     = 1'b0;
    tmr_load_val = 4'd0;
    tmr_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.req) begin
          we_d       = io.we;
          addr_d     = io.addr;
          wdata_d    = io.wdata;
          disp_hit_d = disp_hit_now;
          if (disp_hit_now) begin
            state_d = DONE;
          end else begin
            state_d      = ADDR;
            tmr_load     = 1'b1;
            tmr_load_val = phase_load(LE_CYCLES);
          end
        end
      end
      ADDR: begin
        if (tmr_zero) state_d = HOLD;
        else          tmr_dec = 1'b1;
      end
      HOLD: begin
        if (we_q) begin
          state_d = WDATA;
        end else begin
          state_d      = RD;
          tmr_load     = 1'b1;
          tmr_load_val = phase_load(RD_WAIT);
        end
      end
      RD: begin
        if (tmr_zero) state_d = SAMPLE;
        else          tmr_dec = 1'b1;
      end
      SAMPLE: state_d = DONE;
      WDATA: begin
        state_d      = WSTB;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(WR_CYCLES);
      end
      WSTB: begin
        if (tmr_zero) state_d = DONE;
        else          tmr_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad outputs are registered images of the current state, so every strobe lags the state by one cycle.
  always_comb begin
    le_d      = (state_q == ADDR);
    moe_d     = (state_q == RD) || (state_q == SAMPLE);
    mwe_d     = (state_q == WSTB);
    ack_d     = (state_q == DONE);
    bus_oe_d  = BUS_RELEASE;
    bus_out_d = 8'h00;
    rdata_d   = rdata_q;
    case (state_q)
      ADDR, HOLD: begin
        bus_oe_d  = BUS_DRIVE;
        bus_out_d = addr_q;
      end
      WDATA, WSTB: begin
        bus_oe_d  = BUS_DRIVE;
        bus_out_d = wdata_q;
      end
      DONE: begin
        if (we_q && !disp_hit_q) begin
          bus_oe_d  = BUS_DRIVE;
          bus_out_d = wdata_q;
        end
        // This edge closes the last cycle in which moe is visible on the pads.
        if (!we_q) rdata_d = io.bus_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      disp_hit_q <= 1'b0;
      le_q       <= 1'b0;
      moe_q      <= 1'b0;
      mwe_q      <= 1'b0;
      ack_q      <= 1'b0;
      bus_oe_q   <= BUS_RELEASE;
      bus_out_q  <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      disp_hit_q <= disp_hit_d;
      le_q       <= le_d;
      moe_q      <= moe_d;
      mwe_q      <= mwe_d;
      ack_q      <= ack_d;
      bus_oe_q   <= bus_oe_d;
      bus_out_q  <= bus_out_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef SUBNEG_DISPLAY_EN
  logic [7:0] disp_q, disp_d;

  always_comb begin
    disp_d = disp_q;
    if (state_q == DONE && disp_hit_q) disp_d = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= 8'h00;
    else        disp_q <= disp_d;
  end

  assign io.disp = disp_q;
`else
  assign io.disp = 8'h00;
`endif

  assign io.le      = le_q;
  assign io.moe     = moe_q;
  assign io.mwe     = mwe_q;
  assign io.ack     = ack_q;
  assign io.bus_oe  = bus_oe_q;
  assign io.bus_out = bus_out_q;
  assign io.rdata   = rdata_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_subneg_mem_seq.sv
// Directed bench for subneg_mem_seq: default-timing DUT (a) and stretched-timing DUT (b), each with a memory model.
module tb_subneg_mem_seq;
  import subneg_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  subneg_mem_seq_if ifa ();
  subneg_mem_seq_if ifb ();
  state_e state_a;
  state_e state_b;

  subneg_mem_seq dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (ifa.slave),
    .state_dbg (state_a)
  );

  subneg_mem_seq #(
    .LE_CYCLES (3),
    .RD_WAIT   (4),
    .WR_CYCLES (2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (ifb.slave),
    .state_dbg (state_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory models: address latch follows the bus while le is high.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] lat_a, lat_b;
  logic       poke_en, poke_sel;
  logic [7:0] poke_addr, poke_data;

  always @(posedge clk) begin
    if (ifa.le) lat_a <= ifa.bus_out;
    if (ifb.le) lat_b <= ifb.bus_out;
    if (poke_en && !poke_sel) mem_a[poke_addr] <= poke_data;
    else if (ifa.mwe)         mem_a[lat_a] <= ifa.bus_out;
    if (poke_en && poke_sel)  mem_b[poke_addr] <= poke_data;
    else if (ifb.mwe)         mem_b[lat_b] <= ifb.bus_out;
  end

  assign ifa.bus_in = ifa.moe ? mem_a[lat_a] : 8'h00;
  assign ifb.bus_in = ifb.moe ? mem_b[lat_b] : 8'h00;

  typedef struct packed {
    logic       le, moe, mwe, ack;
    logic [7:0] oe, out, rdata, disp;
  } obs_t;

  function automatic obs_t observe(input bit sel);
    obs_t o;
    if (sel) o = '{ifb.le, ifb.moe, ifb.mwe, ifb.ack, ifb.bus_oe, ifb.bus_out, ifb.rdata, ifb.disp};
    else     o = '{ifa.le, ifa.moe, ifa.mwe, ifa.ack, ifa.bus_oe, ifa.bus_out, ifa.rdata, ifa.disp};
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input bit sel, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (sel) begin ifb.req = r; ifb.we = w; ifb.addr = a; ifb.wdata = d; end
    else     begin ifa.req = r; ifa.we = w; ifa.addr = a; ifa.wdata = d; end
  endtask

  task automatic poke(input bit sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Per-cycle structural checks made on every observed cycle of a transaction.
  task automatic cycle_checks(input obs_t o);
    check("strobe_excl", 32'((o.le & o.moe) | (o.le & o.mwe) | (o.moe & o.mwe)), 32'd0);
    check("oe_vs_moe", 32'(o.moe && o.oe == 8'hFF), 32'd0);
    check("oe_legal", 32'(o.oe == 8'h00 || o.oe == 8'hFF), 32'd1);
  endtask

  logic [7:0] tr_out [64];
  logic [7:0] tr_oe  [64];
  logic       tr_mwe [64];
  int         tr_len;

  // Issues one request, waits (bounded) for ack, drops req at the ack cycle.
  // edges = posedges from the accepting edge to the edge that raised ack.
  task automatic run_txn(input bit sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                         output int edges, output int n_le, output int n_moe, output int n_mwe);
    obs_t o;
    bit   done;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    edges = 0; n_le = 0; n_moe = 0; n_mwe = 0; tr_len = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      o = observe(sel);
      cycle_checks(o);
      tr_out[tr_len] = o.out; tr_oe[tr_len] = o.oe; tr_mwe[tr_len] = o.mwe;
      tr_len++;
      n_le  += int'(o.le);
      n_moe += int'(o.moe);
      n_mwe += int'(o.mwe);
      if (o.ack) begin
        done = 1'b1;
        drive(sel, 1'b0, w, a, d);
      end
    end
    check("ack_timeout", 32'(done), 32'd1);
    edges = edges - 1;
  endtask

  obs_t o;
  int   edges, n_le, n_moe, n_mwe, idx, gap, acks;
  bit   seen;

  initial begin
    n_checks = 0; n_fail = 0;
    poke_en = 1'b0; poke_sel = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    o = observe(1'b0);
    check("rst_le", 32'(o.le), 32'd0);
    check("rst_moe", 32'(o.moe), 32'd0);
    check("rst_mwe", 32'(o.mwe), 32'd0);
    check("rst_ack", 32'(o.ack), 32'd0);
    check("rst_oe", 32'(o.oe), 32'h00);
    check("rst_out", 32'(o.out), 32'h00);
    check("rst_rdata", 32'(o.rdata), 32'h00);
    check("rst_disp", 32'(o.disp), 32'h00);
    rst_n = 1'b1;

    poke(1'b0, 8'h10, 8'h5A);
    poke(1'b0, 8'h01, 8'h33);
    poke(1'b1, 8'h30, 8'hFF);

    // Default read
    run_txn(1'b0, 1'b0, 8'h10, 8'h00, edges, n_le, n_moe, n_mwe);
    check("rd_edges", 32'(edges), 32'd5);
    check("rd_le_cycles", 32'(n_le), 32'd1);
    check("rd_moe_cycles", 32'(n_moe), 32'd2);
    check("rd_mwe_cycles", 32'(n_mwe), 32'd0);
    check("rd_data", 32'(ifa.rdata), 32'h5A);

    // Default write
    run_txn(1'b0, 1'b1, 8'h22, 8'hC3, edges, n_le, n_moe, n_mwe);
    check("wr_edges", 32'(edges), 32'd5);
    check("wr_le_cycles", 32'(n_le), 32'd1);
    check("wr_mwe_cycles", 32'(n_mwe), 32'd1);
    check("wr_moe_cycles", 32'(n_moe), 32'd0);
    check("wr_mem", 32'(mem_a[8'h22]), 32'hC3);
    check("wr_rdata_kept", 32'(ifa.rdata), 32'h5A);
    idx = 0;
    for (int i = 0; i < tr_len; i++) if (tr_mwe[i] && idx == 0) idx = i;
    check("wr_setup", 32'((idx > 0) ? {tr_oe[idx-1], tr_out[idx-1]} : 16'h0), 32'hFFC3);
    check("wr_hold", 32'((idx > 0 && idx + 1 < tr_len) ? {tr_oe[idx+1], tr_out[idx+1]} : 16'h0), 32'hFFC3);

    // Stretched timing on DUT b
    run_txn(1'b1, 1'b0, 8'h30, 8'h00, edges, n_le, n_moe, n_mwe);
    check("long_rd_edges", 32'(edges), 32'd10);
    check("long_rd_le", 32'(n_le), 32'd3);
    check("long_rd_moe", 32'(n_moe), 32'd5);
    check("long_rd_data", 32'(ifb.rdata), 32'hFF);
    run_txn(1'b1, 1'b1, 8'h31, 8'h81, edges, n_le, n_moe, n_mwe);
    check("long_wr_edges", 32'(edges), 32'd8);
    check("long_wr_mwe", 32'(n_mwe), 32'd2);
    check("long_wr_mem", 32'(mem_b[8'h31]), 32'h81);

    // Display register write
    run_txn(1'b0, 1'b1, 8'd21, 8'h7E, edges, n_le, n_moe, n_mwe);
`ifdef SUBNEG_DISPLAY_EN
    check("disp_edges", 32'(edges), 32'd1);
    check("disp_value", 32'(ifa.disp), 32'h7E);
    check("disp_no_le", 32'(n_le), 32'd0);
    check("disp_no_mwe", 32'(n_mwe), 32'd0);
    check("disp_no_oe", 32'(ifa.bus_oe), 32'h00);
`else
    check("disp_edges", 32'(edges), 32'd5);
    check("disp_value", 32'(ifa.disp), 32'h00);
    check("disp_ext_mwe", 32'(n_mwe), 32'd1);
    check("disp_ext_mem", 32'(mem_a[8'd21]), 32'h7E);
`endif

    // Back-to-back: req held through the ack, next request presented at once
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    acks = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifa.ack) begin
        seen = 1'b1; acks++;
        drive(1'b0, 1'b1, 1'b1, 8'h02, 8'h44);
      end
    end
    check("b2b_first_ack", 32'(seen), 32'd1);
    check("b2b_rdata", 32'(ifa.rdata), 32'h33);
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (ifa.le) seen = 1'b1;
    end
    check("b2b_gap", 32'(gap), 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifa.ack) begin
        seen = 1'b1; acks++;
        drive(1'b0, 1'b0, 1'b1, 8'h02, 8'h44);
      end
    end
    check("b2b_acks", 32'(acks), 32'd2);
    check("b2b_mem", 32'(mem_a[8'h02]), 32'h44);

    // Reset during the write strobe
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h99);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifa.mwe) seen = 1'b1;
    end
    check("rst_wr_reached_wstb", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    o = observe(1'b0);
    check("abort_mwe", 32'(o.mwe), 32'd0);
    check("abort_le", 32'(o.le), 32'd0);
    check("abort_moe", 32'(o.moe), 32'd0);
    check("abort_oe", 32'(o.oe), 32'h00);
    check("abort_ack", 32'(o.ack), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(ifa.ack);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ifa.ack);
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    run_txn(1'b0, 1'b0, 8'h10, 8'h00, edges, n_le, n_moe, n_mwe);
    check("post_rst_edges", 32'(edges), 32'd5);
    check("post_rst_rdata", 32'(ifa.rdata), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subneg_mem_seq.md
# subneg_mem_seq

External-memory bus sequencer for the SUBNEG core. Converts single-word read/write requests from the core's instruction/operand state machine into timed cycles on the shared 8-bit multiplexed address/data pad bus, driving the external address latch (LE), memory output enable (MOE) and memory write enable (MWE). It sits directly downstream of the core, between the core's fetch/execute FSM and the uio pads. It also owns the optional memory-mapped display register.

## Interface
- LE_CYCLES, 1: cycles LE is held high with the address driven; legal range 1..15.
- RD_WAIT, 1: cycles MOE is high before rdata is sampled; legal range 1..15.
- WR_CYCLES, 1: width of the MWE pulse in cycles; legal range 1..15.
- DISP_ADDR, 8'd21: address of the display register (used only with SUBNEG_DISPLAY_EN).
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  core request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  8  word address; captured with req.
- wdata  in  8  write data; captured with req.
- rdata  out  8  read data; valid from the ack cycle until the next read completes.
- ack  out  1  one-cycle completion pulse.
- bus_out  out  8  pad bus drive value (address or write data).
- bus_oe  out  8  pad output enable; always 8'hFF or 8'h00.
- bus_in  in  8  pad bus input.
- le  out  1  external address latch enable; latch is transparent while high.
- moe  out  1  memory output enable.
- mwe  out  1  memory write enable.
- disp  out  8  display register.

## Operation
- Reset: state IDLE. le=0, moe=0, mwe=0, bus_oe=8'h00, bus_out=8'h00, ack=0, rdata=8'h00, disp=8'h00. Reset assertion in any state aborts the transaction immediately. No ack is issued and all strobes drop asynchronously.
- IDLE: bus released (bus_oe=00). When req=1, capture addr/we/wdata. Go to ADDR, or to DONE for a display write.
- ADDR: bus_out=addr, bus_oe=FF, le=1 for LE_CYCLES cycles, then HOLD.
- HOLD: le=0; address is still driven for 1 cycle (latch hold time). Then RD if we=0, WDATA if we=1.
- RD: bus_oe=00, moe=1 for RD_WAIT cycles, then SAMPLE.
- SAMPLE: moe=1. rdata<=bus_in at the end of the cycle. Then DONE.
- WDATA: bus_out=wdata, bus_oe=FF, mwe=0 for 1 cycle (data setup), then WSTB.
- WSTB: mwe=1 for WR_CYCLES cycles, data still driven, then DONE.
- DONE: ack=1, moe=0, mwe=0. Data is still driven after a write (hold). Then IDLE.
- Strobe exclusivity: le, moe and mwe are never high together. bus_oe=FF never coincides with moe=1.
- req is ignored outside IDLE. A req held high through DONE is accepted in the following IDLE cycle, so back-to-back transactions have one IDLE gap.
- The core holds req high until it sees ack. Captured values make later changes to addr/wdata harmless.

## Timing
- All outputs are registered.
- Read: ack is high in the cycle beginning LE_CYCLES+RD_WAIT+3 edges after the accepting edge. With defaults this is 5.
- Write: ack comes LE_CYCLES+WR_CYCLES+3 edges after acceptance. With defaults this is 5.
- Display write: ack comes 1 edge after acceptance, with no bus activity.
- Phase counters are 4 bits and load the parameter value minus 1. A parameter value of 1 gives a single-cycle phase.

## Configuration
- SUBNEG_DISPLAY_EN defined:
  - A write with addr==DISP_ADDR updates disp with wdata and takes the short path (IDLE→DONE). No external write is performed.
  - Reads of DISP_ADDR still go to external memory.
- SUBNEG_DISPLAY_EN undefined:
  - disp is tied to 8'h00.
  - All writes, including to DISP_ADDR, perform full external cycles.

## Structure
- Package subneg_pkg holds:
  - the state enum (IDLE, ADDR, HOLD, RD, SAMPLE, WDATA, WSTB, DONE);
  - the default DISP_ADDR constant;
  - the BUS_DRIVE=8'hFF and BUS_RELEASE=8'h00 constants.
- One sub-module, subneg_phase_timer: a 4-bit loadable down-counter with a zero flag, shared by the ADDR, RD and WSTB phases.

## Test plan
- Default read: memory model holds 8'h5A at 8'h10, req/we=0/addr=8'h10 → le high 1 cycle, moe high 2 cycles, ack in the 5th cycle, rdata=8'h5A, bus_oe=00 while moe=1.
- Default write: we=1, addr=8'h22, wdata=8'hC3 → model memory[8'h22]=8'hC3, single 1-cycle mwe pulse with data valid one cycle either side, ack in the 5th cycle.
- Stretched timing: LE_CYCLES=3, RD_WAIT=4, read 8'hFF → ack after 10 edges, rdata correct, no strobe overlap (assertion).
- Back-to-back: req held high across read 8'h01 then write 8'h02 → exactly one IDLE cycle between DONE and the next ADDR. Two acks total.
- Display (SUBNEG_DISPLAY_EN defined): write 8'h7E to 8'd21 → disp=8'h7E, ack on the next edge, le/mwe never asserted. Without the macro: external write occurs and disp stays 8'h00.
- Reset mid-write: drop rst_n during WSTB → mwe, le and moe go low and bus_oe goes to 00 immediately, no ack. After release, a new read completes normally.
